// File: rtl/key_collector.sv
// Collects the first key recovered by the parallel workers, stops the search,
// times it, and streams the winning key out MSB byte first over valid/ready.
module key_collector #(
  parameter int total = 4,
  parameter int CW    = 32,
  parameter int IW    = (total > 1) ? $clog2(total) : 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [total-1:0]   i_found,
  input  logic [128*total-1:0] i_keys,
  input  logic [total-1:0]   i_exhausted,
  output logic               o_stop,
  output logic               o_busy,
  output logic               o_hit,
  output logic               o_miss,
  output logic [IW-1:0]      o_winner,
  output logic [127:0]       o_key,
  output logic [CW-1:0]      o_cycles,
  output logic [7:0]         o_byte_data,
  output logic               o_byte_valid,
  input  logic               i_byte_ready
);

  typedef enum logic [1:0] {IDLE, SEARCH, SEND, DONE} state_t;

  state_t         r_state, w_state;
  logic           r_hit, w_hit;
  logic           r_miss, w_miss;
  logic [IW-1:0]  r_winner, w_winner;
  logic [127:0]   r_key, w_key;
  logic [CW-1:0]  r_cycles, w_cycles;
  logic [3:0]     r_idx, w_idx;
  logic [7:0]     r_byte_data, w_byte_data;
  logic           r_byte_valid, w_byte_valid;
  logic           r_stop, w_stop;
  logic           r_busy, w_busy;

  logic           w_any;
  logic [IW-1:0]  w_sel;
  logic [127:0]   w_sel_key;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state      <= IDLE;
      r_hit        <= 1'b0;
      r_miss       <= 1'b0;
      r_winner     <= '0;
      r_key        <= '0;
      r_cycles     <= '0;
      r_idx        <= '0;
      r_byte_data  <= '0;
      r_byte_valid <= 1'b0;
      r_stop       <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_hit        <= w_hit;
      r_miss       <= w_miss;
      r_winner     <= w_winner;
      r_key        <= w_key;
      r_cycles     <= w_cycles;
      r_idx        <= w_idx;
      r_byte_data  <= w_byte_data;
      r_byte_valid <= w_byte_valid;
      r_stop       <= w_stop;
      r_busy       <= w_busy;
    end
  end

  // Walk from the top down so the lowest-index hit is the one left standing.
  always_comb begin
    w_any     = 1'b0;
    w_sel     = '0;
    w_sel_key = '0;
    for (int i = total - 1; i >= 0; i--) begin
      if (i_found[i]) begin
        w_any     = 1'b1;
        w_sel     = IW'(i);
        w_sel_key = i_keys[128*i +: 128];
      end
    end
  end

  always_comb begin
    w_state      = r_state;
    w_hit        = r_hit;
    w_miss       = r_miss;
    w_winner     = r_winner;
    w_key        = r_key;
    w_cycles     = r_cycles;
    w_idx        = r_idx;
    w_byte_data  = r_byte_data;
    w_byte_valid = r_byte_valid;

    case (r_state)
      IDLE, DONE: begin
        if (i_start) begin
          w_state  = SEARCH;
          w_hit    = 1'b0;
          w_miss   = 1'b0;
          w_key    = '0;
          w_winner = '0;
          w_cycles = '0;
        end
      end
      SEARCH: begin
        if (i_start) begin
          w_hit    = 1'b0;
          w_miss   = 1'b0;
          w_key    = '0;
          w_winner = '0;
          w_cycles = '0;
        end else if (w_any) begin
          w_state      = SEND;
          w_key        = w_sel_key;
          w_winner     = w_sel;
          w_hit        = 1'b1;
          w_idx        = '0;
          w_byte_data  = w_sel_key[127:120];
          w_byte_valid = 1'b1;
        end else if (&i_exhausted) begin
          w_state = DONE;
          w_miss  = 1'b1;
        end else if (r_cycles != '1) begin
          w_cycles = r_cycles + CW'(1);
        end
      end
      SEND: begin
        if (i_byte_ready) begin
          if (r_idx == 4'd15) begin
            w_state      = DONE;
            w_idx        = '0;
            w_byte_valid = 1'b0;
            w_byte_data  = '0;
          end else begin
            w_idx       = r_idx + 4'd1;
            w_byte_data = r_key[8*(14 - int'(r_idx)) +: 8];
          end
        end
      end
      default: w_state = IDLE;
    endcase

    w_stop = (w_state == SEND) || (w_state == DONE);
    w_busy = (w_state == SEARCH) || (w_state == SEND);
  end

  assign o_stop       = r_stop;
  assign o_busy       = r_busy;
  assign o_hit        = r_hit;
  assign o_miss       = r_miss;
  assign o_winner     = r_winner;
  assign o_key        = r_key;
  assign o_cycles     = r_cycles;
  assign o_byte_data  = r_byte_data;
  assign o_byte_valid = r_byte_valid;

endmodule

// File: tb/tb_key_collector.sv
// Directed bench for key_collector with four workers.
module tb_key_collector;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b0;
  logic         i_start = 1'b0;
  logic [3:0]   i_found = '0;
  logic [511:0] i_keys = '0;
  logic [3:0]   i_exhausted = '0;
  logic         i_byte_ready = 1'b0;
  logic         o_stop, o_busy, o_hit, o_miss, o_byte_valid;
  logic [1:0]   o_winner;
  logic [127:0] o_key;
  logic [31:0]  o_cycles;
  logic [7:0]   o_byte_data;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [127:0] K2 = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [127:0] K1 = 128'h11112222333344445555666677778888;
  localparam logic [127:0] K3 = 128'hA5A5A5A5DEADBEEFCAFEF00D00C0FFEE;
  localparam logic [127:0] K0 = 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F;

  key_collector #(.total(4), .CW(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_found(i_found),
    .i_keys(i_keys), .i_exhausted(i_exhausted), .o_stop(o_stop), .o_busy(o_busy),
    .o_hit(o_hit), .o_miss(o_miss), .o_winner(o_winner), .o_key(o_key),
    .o_cycles(o_cycles), .o_byte_data(o_byte_data), .o_byte_valid(o_byte_valid),
    .i_byte_ready(i_byte_ready)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " stop"}, 128'(o_stop), 0);
    chk({tag, " busy"}, 128'(o_busy), 0);
    chk({tag, " hit"}, 128'(o_hit), 0);
    chk({tag, " miss"}, 128'(o_miss), 0);
    chk({tag, " winner"}, 128'(o_winner), 0);
    chk({tag, " key"}, o_key, 0);
    chk({tag, " cycles"}, 128'(o_cycles), 0);
    chk({tag, " byte_data"}, 128'(o_byte_data), 0);
    chk({tag, " byte_valid"}, 128'(o_byte_valid), 0);
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  // Consume all 16 bytes with ready held high, checking each against key k.
  task automatic drain(input string tag, input logic [127:0] k);
    logic [127:0] kv;
    kv = k;
    i_byte_ready = 1'b1;
    for (int b = 0; b < 16; b++) begin
      chk({tag, " valid"}, 128'(o_byte_valid), 1);
      chk({tag, " byte"}, 128'(o_byte_data), 128'(kv[127-8*b -: 8]));
      tick();
    end
    chk({tag, " busy after"}, 128'(o_busy), 0);
    chk({tag, " valid after"}, 128'(o_byte_valid), 0);
    chk({tag, " stop after"}, 128'(o_stop), 1);
  endtask

  initial begin
    logic [127:0] kv;
    int idx;
    int iter;

    // Reset state
    repeat (2) @(posedge i_clk);
    #1;
    chk_all_zero("reset");
    i_rst = 1'b1;
    tick();

    // Single hit from worker 2 after 10 edges
    pulse_start();
    chk("t1 busy", 128'(o_busy), 1);
    chk("t1 cycles0", 128'(o_cycles), 0);
    chk("t1 stop0", 128'(o_stop), 0);
    repeat (9) tick();
    i_keys[128*2 +: 128] = K2;
    i_found = 4'b0100;
    i_byte_ready = 1'b1;
    tick();
    i_found = 4'b0000;
    chk("t1 hit", 128'(o_hit), 1);
    chk("t1 winner", 128'(o_winner), 2);
    chk("t1 cycles", 128'(o_cycles), 9);
    chk("t1 stop", 128'(o_stop), 1);
    chk("t1 key", o_key, K2);
    drain("t1 send", K2);
    chk("t1 hit held", 128'(o_hit), 1);
    chk("t1 key held", o_key, K2);

    // Simultaneous hits: lowest index wins, on the first SEARCH edge
    i_keys = '0;
    i_keys[128*1 +: 128] = K1;
    i_keys[128*3 +: 128] = K3;
    pulse_start();
    chk("t2 hit cleared", 128'(o_hit), 0);
    chk("t2 key cleared", o_key, 0);
    i_found = 4'b1010;
    tick();
    i_found = 4'b0000;
    chk("t2 winner", 128'(o_winner), 1);
    chk("t2 key", o_key, K1);
    chk("t2 cycles", 128'(o_cycles), 0);
    drain("t2 send", K1);

    // All workers exhausted, no hit
    pulse_start();
    i_exhausted = 4'b1111;
    tick();
    i_exhausted = 4'b0000;
    chk("t3 miss", 128'(o_miss), 1);
    chk("t3 hit", 128'(o_hit), 0);
    chk("t3 key", o_key, 0);
    chk("t3 stop", 128'(o_stop), 1);
    chk("t3 busy", 128'(o_busy), 0);
    chk("t3 valid", 128'(o_byte_valid), 0);
    chk("t3 cycles", 128'(o_cycles), 0);
    tick();
    chk("t3 valid later", 128'(o_byte_valid), 0);

    // Hit and exhaustion together, then a throttled transfer with a stray start
    i_keys = '0;
    i_keys[127:0] = K0;
    pulse_start();
    chk("t4 miss cleared", 128'(o_miss), 0);
    i_found = 4'b0001;
    i_exhausted = 4'b1111;
    tick();
    i_found = 4'b0000;
    i_exhausted = 4'b0000;
    chk("t4 hit", 128'(o_hit), 1);
    chk("t4 miss", 128'(o_miss), 0);
    chk("t4 winner", 128'(o_winner), 0);
    kv = K0;
    idx = 0;
    iter = 0;
    while (idx < 16 && iter < 100) begin
      i_byte_ready = (iter % 4 == 0) || (iter % 4 == 3);
      i_start = (iter == 5);
      chk("t4 valid", 128'(o_byte_valid), 1);
      chk("t4 byte", 128'(o_byte_data), 128'(kv[127-8*idx -: 8]));
      tick();
      if (i_byte_ready) idx++;
      iter++;
    end
    i_start = 1'b0;
    chk("t4 bytes sent", 128'(idx), 16);
    chk("t4 busy after", 128'(o_busy), 0);
    chk("t4 valid after", 128'(o_byte_valid), 0);
    chk("t4 hit held", 128'(o_hit), 1);
    chk("t4 key held", o_key, K0);

    // Reset in the middle of a transfer, then a fresh search
    i_keys = '0;
    i_keys[128*2 +: 128] = K2;
    i_keys[128*1 +: 128] = K1;
    pulse_start();
    repeat (3) tick();
    i_found = 4'b0100;
    i_byte_ready = 1'b1;
    tick();
    i_found = 4'b0000;
    chk("t5 cycles", 128'(o_cycles), 3);
    repeat (5) tick();
    kv = K2;
    chk("t5 byte5", 128'(o_byte_data), 128'(kv[87:80]));
    #1;
    i_rst = 1'b0;
    #1;
    chk_all_zero("t5 async reset");
    #1;
    i_rst = 1'b1;
    tick();
    pulse_start();
    chk("t5 fresh cycles", 128'(o_cycles), 0);
    repeat (2) tick();
    i_found = 4'b0010;
    tick();
    i_found = 4'b0000;
    chk("t5 new cycles", 128'(o_cycles), 2);
    chk("t5 new winner", 128'(o_winner), 1);
    drain("t5 send", K1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
